// File: rtl/dec38_pkg.sv
// Shared types and helpers for the 3-to-8 decode / LED hold path.
package dec38_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned IDX_W     = 3;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [NUM_LINES-1:0] onehot_t;

  // Per-line counter action chosen each cycle.
  typedef enum logic [1:0] {
    CNT_KEEP = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_ZERO = 2'd3
  } cnt_op_e;

  // Priority: clear, then reload on hit, then countdown (non-sticky only), else keep.
  function automatic cnt_op_e sel_cnt_op(
    input logic clr,
    input logic load,
    input logic sticky,
    input logic nonzero
  );
    cnt_op_e op;
    op = CNT_KEEP;
    if (clr) begin
      op = CNT_ZERO;
    end else if (load) begin
      op = CNT_LOAD;
    end else if (!sticky && nonzero) begin
      op = CNT_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/dec38.sv
// Combinational 3-to-8 decoder with enable; yields per-line load strobes.
module dec38
  import dec38_pkg::*;
(
  input  logic                 i_en,
  input  logic [IDX_W-1:0]     i_x,
  output logic [NUM_LINES-1:0] o_onehot
);

  // One-hot decode of the index, all zero when disabled.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_x] = 1'b1;
    end
  end

endmodule

// File: rtl/dec38_hold.sv
// Decodes strobed {idc, y} codes onto an 8-line LED bank with per-line
// retriggerable hold timers, and keeps the last accepted index for the
// seven-segment path as {last_vld, last_y}.
module dec38_hold
  import dec38_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5_000_000,
  parameter bit          STICKY      = 1'b0,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_strobe,
  input  logic                 i_en,
  input  logic                 i_idc,
  input  logic [IDX_W-1:0]     i_y,
  input  logic                 i_clr,
  output logic [NUM_LINES-1:0] o_led,
  output logic                 o_active,
  output logic [IDX_W-1:0]     o_last_y,
  output logic                 o_last_vld
);

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

  logic    w_acc;
  onehot_t w_load;
  onehot_t w_led_nxt;

  onehot_t r_led;
  logic    r_active;
  idx_t    r_last_y;
  logic    r_last_vld;

  // clr suppresses acceptance so a colliding strobe is dropped outright.
  assign w_acc = i_strobe & i_en & i_idc & ~i_clr;

  dec38 u_dec (
    .i_en     (w_acc),
    .i_x      (i_y),
    .o_onehot (w_load)
  );

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    cnt_op_e          w_op;

    // Next counter value: reload saturates at HOLD_VAL, countdown stops at zero.
    always_comb begin
      w_op      = sel_cnt_op(i_clr, w_load[g], 1'(STICKY), |r_cnt);
      w_cnt_nxt = r_cnt;
      unique case (w_op)
        CNT_ZERO: w_cnt_nxt = '0;
        CNT_LOAD: w_cnt_nxt = HOLD_VAL;
        CNT_DEC:  w_cnt_nxt = r_cnt - CNT_W'(1);
        CNT_KEEP: w_cnt_nxt = r_cnt;
        default:  w_cnt_nxt = r_cnt;
      endcase
    end

    // Per-line hold counter.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

    // LED state derives from the next count so the line rises on the accept edge.
    assign w_led_nxt[g] = |w_cnt_nxt;
  end

  // LED bank and summary bit registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led    <= '0;
      r_active <= 1'b0;
    end else begin
      r_led    <= w_led_nxt;
      r_active <= |w_led_nxt;
    end
  end

  // Last accepted index; clr invalidates it but keeps the value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_y   <= '0;
      r_last_vld <= 1'b0;
    end else if (i_clr) begin
      r_last_vld <= 1'b0;
    end else if (w_acc) begin
      r_last_y   <= i_y;
      r_last_vld <= 1'b1;
    end
  end

  assign o_led      = r_led;
  assign o_active   = r_active;
  assign o_last_y   = r_last_y;
  assign o_last_vld = r_last_vld;

endmodule

// File: tb/tb_dec38_hold.sv
// Randomized and directed bench for dec38_hold; a timed and a sticky
// instance share the same stimulus and are compared to an expiry-time model.
module tb_dec38_hold;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic       en;
  logic       idc;
  logic [2:0] y;
  logic       clr;

  logic [7:0] led_a;
  logic       active_a;
  logic [2:0] last_y_a;
  logic       last_vld_a;
  logic [7:0] led_s;
  logic       active_s;
  logic [2:0] last_y_s;
  logic       last_vld_s;

  int n_checks;
  int n_pass;

  // Model state: edge count, expiry edge per line (timed), hit flag (sticky).
  longint     cyc;
  longint     exp_a [8];
  bit         hit_s [8];
  logic [2:0] m_last_y;
  logic       m_last_vld;

  dec38_hold #(.HOLD_CYCLES(HOLD), .STICKY(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_strobe(strobe), .i_en(en), .i_idc(idc),
    .i_y(y), .i_clr(clr), .o_led(led_a), .o_active(active_a),
    .o_last_y(last_y_a), .o_last_vld(last_vld_a)
  );

  dec38_hold #(.HOLD_CYCLES(HOLD), .STICKY(1'b1)) u_dut_s (
    .i_clk(clk), .i_rst(rst), .i_strobe(strobe), .i_en(en), .i_idc(idc),
    .i_y(y), .i_clr(clr), .o_led(led_s), .o_active(active_s),
    .o_last_y(last_y_s), .o_last_vld(last_vld_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_led_a();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (cyc < exp_a[i]);
    return r;
  endfunction

  function automatic logic [7:0] m_led_s();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = hit_s[i];
    return r;
  endfunction

  task automatic model_edge();
    cyc++;
    if (rst || clr) begin
      for (int i = 0; i < 8; i++) begin
        exp_a[i] = 0;
        hit_s[i] = 1'b0;
      end
      m_last_vld = 1'b0;
      if (rst) m_last_y = 3'd0;
    end else if (strobe && en && idc) begin
      exp_a[y]   = cyc + HOLD;
      hit_s[y]   = 1'b1;
      m_last_y   = y;
      m_last_vld = 1'b1;
    end
  endtask

  task automatic check_all();
    check("led",      {24'd0, led_a},      {24'd0, m_led_a()});
    check("active",   {31'd0, active_a},   {31'd0, |m_led_a()});
    check("last_y",   {29'd0, last_y_a},   {29'd0, m_last_y});
    check("last_vld", {31'd0, last_vld_a}, {31'd0, m_last_vld});
    check("s_led",    {24'd0, led_s},      {24'd0, m_led_s()});
    check("s_active", {31'd0, active_s},   {31'd0, |m_led_s()});
    check("s_last_y", {29'd0, last_y_s},   {29'd0, m_last_y});
    check("s_vld",    {31'd0, last_vld_s}, {31'd0, m_last_vld});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; strobe = 1'b0; en = 1'b1; idc = 1'b0; y = 3'd0; clr = 1'b0;
  endtask

  task automatic hit(input logic [2:0] idx);
    strobe = 1'b1; en = 1'b1; idc = 1'b1; y = idx;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_last_y = 3'd0;
    m_last_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 0;
      hit_s[i] = 1'b0;
    end
    idle_inputs();

    // Reset then idle.
    do_reset(2);
    for (int i = 0; i < 10; i++) tick();
    check("rst_led", {24'd0, led_a}, 32'h0);
    check("rst_vld", {31'd0, last_vld_a}, 32'h0);

    // Gating: idc=0, then en=0.
    strobe = 1'b1; en = 1'b1; idc = 1'b0; y = 3'd2;
    tick();
    idc = 1'b1; en = 1'b0;
    tick();
    idle_inputs();
    tick();
    check("gate_led", {24'd0, led_a}, 32'h0);
    check("gate_vld", {31'd0, last_vld_a}, 32'h0);

    // Single hit on line 5.
    hit(3'd5);
    tick();
    idle_inputs();
    check("hit_led", {24'd0, led_a}, 32'h20);
    check("hit_last_y", {29'd0, last_y_a}, 32'd5);
    for (int i = 0; i < 3; i++) tick();
    check("hit_hold_end", {24'd0, led_a}, 32'h20);
    tick();
    check("hit_fall", {24'd0, led_a}, 32'h0);
    check("hit_vld_persist", {31'd0, last_vld_a}, 32'd1);
    for (int i = 0; i < 3; i++) tick();

    // Retrigger and overlap: y=3, y=7, y=3 on consecutive edges.
    hit(3'd3); tick();
    hit(3'd7); tick();
    check("overlap_led", {24'd0, led_a}, 32'h88);
    hit(3'd3); tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) tick();

    // Clear collides with a strobe while line 5 is lit.
    hit(3'd5); tick();
    hit(3'd1); clr = 1'b1;
    tick();
    idle_inputs();
    check("clr_led", {24'd0, led_a}, 32'h0);
    check("clr_vld", {31'd0, last_vld_a}, 32'h0);
    check("clr_last_y", {29'd0, last_y_a}, 32'd5);
    tick();

    // Sticky hold, then reset mid-hold.
    hit(3'd0); tick();
    idle_inputs();
    for (int i = 0; i < 50; i++) tick();
    check("sticky_led", {24'd0, led_s}, 32'h01);
    do_reset(1);
    check("sticky_rst_led", {24'd0, led_s}, 32'h0);
    check("sticky_rst_vld", {31'd0, last_vld_s}, 32'h0);

    // Continuous strobe on one line keeps it high.
    hit(3'd6);
    for (int i = 0; i < 10; i++) tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      clr    = ($urandom_range(0, 15) == 0);
      strobe = $urandom_range(0, 1) == 1;
      en     = ($urandom_range(0, 7) != 0);
      idc    = ($urandom_range(0, 7) != 0);
      y      = 3'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
